// File: rtl/feedback_regs.sv
// Four cross-coupled registers stepped a programmable number of times.
// Each run goes IDLE -> RUN -> DONE. In RUN, hold stalls both the updates and the step counter.
module feedback_regs #(
  parameter int WIDTH  = 32,
  parameter int CNT_W  = 8,
  parameter int OFF_D  = 3,
  parameter int OFF_B  = 10,
  parameter int INC_C  = 1,
  parameter int INIT_A = 30,
  parameter int INIT_B = 20,
  parameter int INIT_C = 15,
  parameter int INIT_D = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             start,
  input  logic [CNT_W-1:0] steps,
  input  logic             hold,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [CNT_W-1:0] step_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] K_D  = WIDTH'(OFF_D);
  localparam logic [WIDTH-1:0] K_B  = WIDTH'(OFF_B);
  localparam logic [WIDTH-1:0] K_C  = WIDTH'(INC_C);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO = '0;

  state_t           state;
  logic [CNT_W-1:0] steps_q;
  logic [CNT_W-1:0] cnt_nxt;

  assign cnt_nxt = step_cnt + ONE;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      a        <= WIDTH'(INIT_A);
      b        <= WIDTH'(INIT_B);
      c        <= WIDTH'(INIT_C);
      d        <= WIDTH'(INIT_D);
      step_cnt <= ZERO;
      steps_q  <= ZERO;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load) begin
            a <= a_in;
            b <= b_in;
            c <= c_in;
            d <= d_in;
          end else if (start) begin
            step_cnt <= ZERO;
            steps_q  <= steps;
            // A zero-length run still produces its done pulse.
            if (steps == ZERO) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!hold) begin
            a        <= b + c;
            d        <= a - K_D;
            b        <= d + K_B;
            c        <= c + K_C;
            step_cnt <= cnt_nxt;
            if (cnt_nxt == steps_q) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_feedback_regs.sv
// Self-checking bench for feedback_regs: directed scenarios plus randomized runs
// checked against a per-step arithmetic model of the four registers.
module tb_feedback_regs;

  logic        clk = 1'b0;
  logic        reset, load, start, hold;
  logic [31:0] a_in, b_in, c_in, d_in;
  logic [7:0]  steps;
  logic [31:0] a, b, c, d;
  logic [7:0]  step_cnt;
  logic        busy, done;

  logic        r8, l8, s8, h8;
  logic [7:0]  ai8, bi8, ci8, di8, st8;
  logic [7:0]  a8, b8, c8, d8, cnt8;
  logic        busy8, done8;

  int nchk = 0;
  int nerr = 0;
  logic [31:0] ma, mb, mc, md;

  always #5 clk = ~clk;

  feedback_regs u_dut (
    .clock(clk), .reset(reset), .load(load),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .start(start), .steps(steps), .hold(hold),
    .a(a), .b(b), .c(c), .d(d),
    .step_cnt(step_cnt), .busy(busy), .done(done)
  );

  feedback_regs #(.WIDTH(8)) u_dut8 (
    .clock(clk), .reset(r8), .load(l8),
    .a_in(ai8), .b_in(bi8), .c_in(ci8), .d_in(di8),
    .start(s8), .steps(st8), .hold(h8),
    .a(a8), .b(b8), .c(c8), .d(d8),
    .step_cnt(cnt8), .busy(busy8), .done(done8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One step of the recurrence, all terms from pre-step values.
  task automatic m_upd();
    logic [31:0] na, nb, nc, nd;
    na = mb + mc;
    nd = ma - 32'd3;
    nb = md + 32'd10;
    nc = mc + 32'd1;
    ma = na; mb = nb; mc = nc; md = nd;
  endtask

  task automatic m_init();
    ma = 32'd30; mb = 32'd20; mc = 32'd15; md = 32'd5;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_init();
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b1; start = 1'b1; steps = 8'd4;
    a_in = 32'hdead; b_in = 32'hbeef; c_in = 32'h1; d_in = 32'h2;
    tick();
    reset = 1'b0; load = 1'b0; start = 1'b0;
    m_init();
    nchk++;
    if ({a, b, c, d} !== {ma, mb, mc, md}) begin
      nerr++; $display("FAIL reset_vals: got %0d %0d %0d %0d want 30 20 15 5", a, b, c, d);
    end
    nchk++;
    if ({step_cnt, busy, done} !== 10'd0) begin
      nerr++; $display("FAIL reset_ctrl: got cnt=%0d busy=%b done=%b want 0 0 0", step_cnt, busy, done);
    end
  endtask

  task automatic test_directed();
    do_reset();
    steps = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    nchk++;
    if ({busy, done, step_cnt} !== {1'b1, 1'b0, 8'd0}) begin
      nerr++; $display("FAIL dir_start: got busy=%b done=%b cnt=%0d want 1 0 0", busy, done, step_cnt);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      m_upd();
      nchk++;
      if ({a, b, c, d} !== {ma, mb, mc, md}) begin
        nerr++; $display("FAIL dir_vals%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d", i, a, b, c, d, ma, mb, mc, md);
      end
      nchk++;
      if ({step_cnt, done, busy} !== {8'(i), i == 3, i < 3}) begin
        nerr++; $display("FAIL dir_ctrl%0d: got cnt=%0d done=%b busy=%b", i, step_cnt, done, busy);
      end
    end
    nchk++;
    if ({a, b, c, d} !== {32'd54, 32'd42, 32'd18, 32'd28}) begin
      nerr++; $display("FAIL dir_final: got %0d %0d %0d %0d want 54 42 18 28", a, b, c, d);
    end
    tick();
    nchk++;
    if ({done, busy, step_cnt} !== {1'b0, 1'b0, 8'd3} || {a, b, c, d} !== {ma, mb, mc, md}) begin
      nerr++; $display("FAIL dir_idle: got done=%b busy=%b cnt=%0d a=%0d want 0 0 3 %0d", done, busy, step_cnt, a, ma);
    end
  endtask

  task automatic test_hold();
    int done_edge;
    do_reset();
    steps = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    done_edge = 0;
    for (int e = 2; e <= 7; e++) begin
      hold = (e == 3 || e == 4);
      tick();
      if (done && done_edge == 0) done_edge = e;
      if (e == 2 || e == 3 || e == 4) begin
        nchk++;
        if ({a, b, c, d, step_cnt} !== {32'd35, 32'd15, 32'd16, 32'd27, 8'd1}) begin
          nerr++; $display("FAIL hold_frozen_e%0d: got %0d %0d %0d %0d cnt=%0d want 35 15 16 27 1", e, a, b, c, d, step_cnt);
        end
      end
      if (e == 6) begin
        nchk++;
        if ({a, b, c, d} !== {32'd54, 32'd42, 32'd18, 32'd28}) begin
          nerr++; $display("FAIL hold_final: got %0d %0d %0d %0d want 54 42 18 28", a, b, c, d);
        end
      end
    end
    hold = 1'b0;
    nchk++;
    if (done_edge != 6) begin
      nerr++; $display("FAIL hold_latency: got done at edge %0d want 6", done_edge);
    end
    ma = 32'd54; mb = 32'd42; mc = 32'd18; md = 32'd28;
  endtask

  task automatic test_zero_steps();
    steps = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    nchk++;
    if ({done, busy, step_cnt} !== {1'b1, 1'b0, 8'd0} || {a, b, c, d} !== {ma, mb, mc, md}) begin
      nerr++; $display("FAIL zero_done: got done=%b busy=%b cnt=%0d a=%0d want 1 0 0 %0d", done, busy, step_cnt, a, ma);
    end
    tick();
    nchk++;
    if ({done, busy} !== 2'b00 || {a, b, c, d} !== {ma, mb, mc, md}) begin
      nerr++; $display("FAIL zero_after: got done=%b busy=%b a=%0d want 0 0 %0d", done, busy, a, ma);
    end
  endtask

  task automatic test_load_start();
    a_in = 32'd100; b_in = 32'd200; c_in = 32'd300; d_in = 32'd400;
    load = 1'b1; start = 1'b1; steps = 8'd4;
    tick();
    load = 1'b0; start = 1'b0;
    ma = a_in; mb = b_in; mc = c_in; md = d_in;
    nchk++;
    if ({a, b, c, d} !== {ma, mb, mc, md} || {busy, done} !== 2'b00) begin
      nerr++; $display("FAIL ls_load: got %0d %0d %0d %0d busy=%b want 100 200 300 400 0", a, b, c, d, busy);
    end
    tick();
    nchk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nerr++; $display("FAIL ls_norun: got busy=%b done=%b want 0 0", busy, done);
    end
    steps = 8'd2; start = 1'b1;
    tick();
    a_in = 32'd7; b_in = 32'd7; c_in = 32'd7; d_in = 32'd7;
    load = 1'b1; steps = 8'd7;
    tick(); m_upd();
    tick(); m_upd();
    nchk++;
    if ({a, b, c, d} !== {ma, mb, mc, md} || {done, step_cnt} !== {1'b1, 8'd2}) begin
      nerr++; $display("FAIL ls_inrun: got %0d %0d %0d %0d done=%b cnt=%0d want %0d %0d %0d %0d 1 2", a, b, c, d, done, step_cnt, ma, mb, mc, md);
    end
    tick();
    load = 1'b0; start = 1'b0;
    nchk++;
    if ({a, b, c, d} !== {ma, mb, mc, md} || {done, busy} !== 2'b00) begin
      nerr++; $display("FAIL ls_indone: got a=%0d done=%b busy=%b want %0d 0 0", a, done, busy, ma);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    steps = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_init();
    nchk++;
    if ({a, b, c, d} !== {ma, mb, mc, md} || {busy, done, step_cnt} !== 10'd0) begin
      nerr++; $display("FAIL rmid_vals: got %0d %0d %0d %0d busy=%b done=%b want 30 20 15 5 0 0", a, b, c, d, busy, done);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy || done) bad++;
    end
    nchk++;
    if (bad != 0) begin
      nerr++; $display("FAIL rmid_nodone: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_wrap8();
    ai8 = 8'd0; bi8 = 8'd0; ci8 = 8'd255; di8 = 8'd0; l8 = 1'b1;
    tick();
    l8 = 1'b0; st8 = 8'd1; s8 = 1'b1;
    tick();
    s8 = 1'b0;
    tick();
    nchk++;
    if ({a8, b8, c8, d8} !== {8'd255, 8'd10, 8'd0, 8'd253} || done8 !== 1'b1) begin
      nerr++; $display("FAIL wrap8: got %0d %0d %0d %0d done=%b want 255 10 0 253 1", a8, b8, c8, d8, done8);
    end
  endtask

  task automatic test_random();
    int n, k, cyc;
    for (int it = 0; it < 25; it++) begin
      a_in = $urandom; b_in = $urandom; c_in = $urandom; d_in = $urandom;
      load = 1'b1;
      tick();
      load = 1'b0;
      ma = a_in; mb = b_in; mc = c_in; md = d_in;
      n = $urandom_range(0, 7);
      steps = 8'(n); start = 1'b1;
      tick();
      k = 0; cyc = 0;
      while (k < n && cyc < 64) begin
        hold = ($urandom_range(0, 2) == 0);
        load = $urandom_range(0, 1) == 1;
        start = $urandom_range(0, 1) == 1;
        steps = 8'($urandom);
        a_in = $urandom;
        tick();
        cyc++;
        if (!hold) begin
          m_upd();
          k++;
        end
        nchk++;
        if ({a, b, c, d} !== {ma, mb, mc, md} || step_cnt !== 8'(k) || busy !== (k < n) || done !== (k == n)) begin
          nerr++; $display("FAIL rnd_it%0d_c%0d: got a=%h cnt=%0d busy=%b done=%b want a=%h cnt=%0d", it, cyc, a, step_cnt, busy, done, ma, k);
        end
      end
      if (n == 0) begin
        nchk++;
        if (done !== 1'b1 || busy !== 1'b0 || step_cnt !== 8'd0) begin
          nerr++; $display("FAIL rnd_zero_it%0d: got done=%b busy=%b cnt=%0d want 1 0 0", it, done, busy, step_cnt);
        end
      end
      if (k < n) begin
        nchk++; nerr++;
        $display("FAIL rnd_timeout_it%0d: got %0d steps want %0d", it, k, n);
      end
      hold = 1'b0; load = 1'b0; start = 1'b0;
      tick();
      nchk++;
      if (done !== 1'b0 || busy !== 1'b0 || {a, b, c, d} !== {ma, mb, mc, md}) begin
        nerr++; $display("FAIL rnd_post_it%0d: got done=%b busy=%b a=%h want 0 0 %h", it, done, busy, a, ma);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; hold = 1'b0; steps = 8'd0;
    a_in = '0; b_in = '0; c_in = '0; d_in = '0;
    r8 = 1'b1; l8 = 1'b0; s8 = 1'b0; h8 = 1'b0; st8 = 8'd0;
    ai8 = '0; bi8 = '0; ci8 = '0; di8 = '0;
    tick();
    tick();
    r8 = 1'b0;
    test_reset();
    test_directed();
    test_hold();
    test_zero_steps();
    test_load_start();
    test_reset_mid();
    test_wrap8();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
